// File: rtl/data_sram_resp_if.sv
// Data SRAM request/response bus between the EX/MEM stages and the responder.
// The master issues requests; the slave returns registered read data.
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        rd_valid;

  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, rd_valid
  );

  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, rd_valid
  );
endinterface

// File: rtl/data_sram_resp.sv
// Byte-writable data memory responder with 1-cycle registered read path,
// sticky out-of-range capture and in-range access counters.
module data_sram_resp #(
  parameter int          ADDR_W = 16,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               resetn,
  data_sram_resp_if.slave    bus,
  output logic               acc_err,
  output logic [31:0]        err_addr,
  output logic [31:0]        rd_cnt,
  output logic [31:0]        wr_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              is_rd;
  logic              is_wr;

  logic [31:0] rdata_q, rdata_d;
  logic        rd_valid_q, rd_valid_d;
  logic        acc_err_q, acc_err_d;
  logic [31:0] err_addr_q, err_addr_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;

  // Unsigned wrap makes addresses below BASE land far out of range.
  assign off      = bus.data_sram_addr - BASE;
  assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
  assign idx      = off[ADDR_W+1:2];
  assign is_rd    = bus.data_sram_en && (bus.data_sram_we == 4'b0000);
  assign is_wr    = bus.data_sram_en && (bus.data_sram_we != 4'b0000);

  always_ff @(posedge clk) begin
    if (is_wr && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.data_sram_we[i]) mem[idx][8*i +: 8] <= bus.data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;
    acc_err_d  = acc_err_q;
    err_addr_d = err_addr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    if (is_rd) begin
      rd_valid_d = 1'b1;
      rdata_d    = in_range ? mem[idx] : 32'h0;
      if (in_range) rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (is_wr && in_range) wr_cnt_d = wr_cnt_q + 32'd1;
    if (bus.data_sram_en && !in_range && !acc_err_q) begin
      acc_err_d  = 1'b1;
      err_addr_d = bus.data_sram_addr;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q    <= 32'h0;
      rd_valid_q <= 1'b0;
      acc_err_q  <= 1'b0;
      err_addr_q <= 32'h0;
      rd_cnt_q   <= 32'h0;
      wr_cnt_q   <= 32'h0;
    end else begin
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      acc_err_q  <= acc_err_d;
      err_addr_q <= err_addr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  assign bus.data_sram_rdata = rdata_q;
  assign bus.rd_valid        = rd_valid_q;
  assign acc_err             = acc_err_q;
  assign err_addr            = err_addr_q;
  assign rd_cnt              = rd_cnt_q;
  assign wr_cnt              = wr_cnt_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: directed vector table, reset/idle sequences and
// randomized traffic compared against a behavioural memory model.
module tb_data_sram_resp;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          NW     = 1 << ADDR_W;

  logic        clk;
  logic        resetn;
  logic        acc_err;
  logic [31:0] err_addr, rd_cnt, wr_cnt;

  data_sram_resp_if bus ();

  data_sram_resp #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .acc_err  (acc_err),
    .err_addr (err_addr),
    .rd_cnt   (rd_cnt),
    .wr_cnt   (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem [NW];
  logic [31:0] m_rdata;
  logic        m_valid;
  logic        m_err;
  logic [31:0] m_ea;
  logic [31:0] m_rd, m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_ea = 32'h0;
    m_rd = 32'h0; m_wr = 32'h0;
  endtask

  // Behavioural rules: range test by plain unsigned arithmetic, lane merge by bytes.
  task automatic model_access(input logic en, input logic [3:0] we,
                              input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] o;
    bit          inr;
    int          w;
    o   = addr - BASE;
    inr = o < 32'(4 * NW);
    w   = int'(o / 4) % NW;
    m_valid = 1'b0;
    if (!en) return;
    if (!inr && !m_err) begin m_err = 1'b1; m_ea = addr; end
    if (we == 4'b0) begin
      m_valid = 1'b1;
      m_rdata = inr ? m_mem[w] : 32'h0;
      if (inr) m_rd = m_rd + 1;
    end else if (inr) begin
      for (int b = 0; b < 4; b++)
        if (we[b]) m_mem[w][8*b +: 8] = wdata[8*b +: 8];
      m_wr = m_wr + 1;
    end
  endtask

  task automatic drive(input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_sram_en    = en;
    bus.data_sram_we    = we;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " rdata"},    bus.data_sram_rdata, m_rdata);
    chk({tag, " rd_valid"}, 32'(bus.rd_valid),   32'(m_valid));
    chk({tag, " acc_err"},  32'(acc_err),        32'(m_err));
    chk({tag, " err_addr"}, err_addr,            m_ea);
    chk({tag, " rd_cnt"},   rd_cnt,              m_rd);
    chk({tag, " wr_cnt"},   wr_cnt,              m_wr);
  endtask

  // Called at a negedge: present request, let the edge take it, check at next negedge.
  task automatic step(input string tag, input logic en, input logic [3:0] we,
                      input logic [31:0] addr, input logic [31:0] wdata);
    drive(en, we, addr, wdata);
    @(posedge clk);
    model_access(en, we, addr, wdata);
    @(negedge clk);
    check_model(tag);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] e_rdata;
    logic        e_valid;
    logic        e_err;
    logic [31:0] e_ea;
    logic [31:0] e_rd;
    logic [31:0] e_wr;
  } vec_t;

  vec_t vecs [17];

  initial begin
    vecs[0]  = '{1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h0,        0, 0, 32'h0,  1, 1};
    vecs[0].e_rd = 0;
    vecs[1]  = '{1, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 1, 0, 32'h0,  1, 1};
    vecs[2]  = '{1, 4'h4, 32'h10, 32'h5A5A5A5A, 32'hDEADBEEF, 0, 0, 32'h0,  1, 2};
    vecs[3]  = '{1, 4'h3, 32'h10, 32'h12341234, 32'hDEADBEEF, 0, 0, 32'h0,  1, 3};
    vecs[4]  = '{1, 4'h0, 32'h10, 32'h0,        32'hDE5A1234, 1, 0, 32'h0,  2, 3};
    vecs[5]  = '{1, 4'hF, 32'h20, 32'h11111111, 32'hDE5A1234, 0, 0, 32'h0,  2, 4};
    vecs[6]  = '{1, 4'h0, 32'h20, 32'h0,        32'h11111111, 1, 0, 32'h0,  3, 4};
    vecs[7]  = '{1, 4'hF, 32'h20, 32'h22222222, 32'h11111111, 0, 0, 32'h0,  3, 5};
    vecs[8]  = '{1, 4'h0, 32'h20, 32'h0,        32'h22222222, 1, 0, 32'h0,  4, 5};
    vecs[9]  = '{0, 4'hF, 32'h20, 32'h99999999, 32'h22222222, 0, 0, 32'h0,  4, 5};
    vecs[10] = '{1, 4'h0, 32'h40, 32'h0,        32'h0,        1, 1, 32'h40, 4, 5};
    vecs[11] = '{1, 4'hF, 32'h80, 32'hFFFFFFFF, 32'h0,        0, 1, 32'h40, 4, 5};
    vecs[12] = '{1, 4'h0, 32'h10, 32'h0,        32'hDE5A1234, 1, 1, 32'h40, 5, 5};
    vecs[13] = '{1, 4'h0, 32'hFFFFFFFC, 32'h0,  32'h0,        1, 1, 32'h40, 5, 5};
    vecs[14] = '{1, 4'hF, 32'h3C, 32'hCAFEF00D, 32'h0,        0, 1, 32'h40, 5, 6};
    vecs[15] = '{1, 4'h0, 32'h3C, 32'h0,        32'hCAFEF00D, 1, 1, 32'h40, 6, 6};
    vecs[16] = '{1, 4'h0, 32'h13, 32'h0,        32'hDE5A1234, 1, 1, 32'h40, 7, 6};
  end

  initial begin
    logic [31:0] a, d;
    logic [3:0]  we;
    logic        en;

    for (int i = 0; i < NW; i++) m_mem[i] = 32'h0;
    model_reset();
    drive(0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_model("reset");
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      step(t, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata);
      chk({t, " tbl rdata"},    bus.data_sram_rdata, vecs[i].e_rdata);
      chk({t, " tbl rd_valid"}, 32'(bus.rd_valid),   32'(vecs[i].e_valid));
      chk({t, " tbl acc_err"},  32'(acc_err),        32'(vecs[i].e_err));
      chk({t, " tbl err_addr"}, err_addr,            vecs[i].e_ea);
      chk({t, " tbl rd_cnt"},   rd_cnt,              vecs[i].e_rd);
      chk({t, " tbl wr_cnt"},   wr_cnt,              vecs[i].e_wr);
    end

    // Reset mid-stream: the in-flight read result is dropped immediately.
    drive(1, 4'h0, 32'h20, 32'h0);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_model("midrst");
    @(negedge clk);
    drive(0, 4'h0, 32'h0, 32'h0);
    resetn = 1'b1;
    @(negedge clk);
    step("post_rst_rd10", 1, 4'h0, 32'h10, 32'h0);
    chk("post_rst data10", bus.data_sram_rdata, 32'hDE5A1234);
    step("post_rst_rd20", 1, 4'h0, 32'h20, 32'h0);
    chk("post_rst data20", bus.data_sram_rdata, 32'h22222222);

    for (int i = 0; i < 10; i++)
      step($sformatf("idle%0d", i), 0, 4'hF, $urandom() & 32'hFFFF_FFFC, $urandom());
    step("idle_rd10", 1, 4'h0, 32'h10, 32'h0);
    chk("idle data10", bus.data_sram_rdata, 32'hDE5A1234);

    for (int i = 0; i < NW; i++)
      step($sformatf("init%0d", i), 1, 4'hF, 32'(i) << 2, $urandom());

    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
      case ($urandom_range(0, 7))
        0:       a = $urandom() & 32'hFFFF_FFFC;
        1:       a = 32'($urandom_range(NW, 4 * NW)) << 2;
        default: a = 32'($urandom_range(0, NW - 1)) << 2;
      endcase
      d = $urandom();
      step($sformatf("rnd%0d", i), en, we, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
